hazard_stall_unit: RTL and testbench

- Stall/flush controller for the 5-stage RISC-V pipeline, sitting beside the ID stage.
- Covers the hazards forwarding cannot resolve:
  - load-use;
  - branch-in-ID operand not yet available;
  - taken-branch flush;
  - multi-cycle MUL/DIV occupying EX for MD_LATENCY cycles (an FSM plus down-counter).
- Drives pipeline register write-enables and bubble/flush controls.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_stall_unit_if.sv | 47 ++++
 rtl/md_interlock.sv | 74 +++++++
 rtl/hazard_stall_unit.sv | 97 +++++++++
 tb/tb_hazard_stall_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall unit.
//   md_state_t         : MUL/DIV interlock FSM states (IDLE, BUSY)
//   REG_ZERO           : x0, which never creates a dependency
//   MD_LATENCY_DEFAULT : default EX occupancy of a MUL/DIV instruction
//   reg_match()        : true when rd is non-zero and equals a used source register
package hazard_pkg;

  typedef enum logic [0:0] {IDLE, BUSY} md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MD_LATENCY_DEFAULT = 4;

  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic use_rs1,
                                     input logic [4:0] rs2, input logic use_rs2);
    return (rd != REG_ZERO) && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit bundle.
//   slave  : the hazard unit (reads ID/EX/MEM fields, drives stall/flush controls)
//   master : the pipeline (drives ID/EX/MEM fields, reads stall/flush controls)
// Inputs : ID_RS1, ID_RS2, ID_Use_RS1, ID_Use_RS2, ID_Branch, Branch_Taken,
//          ID_EX_RD, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulDiv, EX_MEM_RD, EX_MEM_MemRead
// Outputs: PC_Write, IF_ID_Write, IF_Flush, ID_EX_NoOp, ID_EX_Hold, EX_MEM_NoOp, MD_Busy,
//          Stall_Cycles, Flush_Count
interface hazard_stall_unit_if;

  logic [4:0]  ID_RS1;
  logic [4:0]  ID_RS2;
  logic        ID_Use_RS1;
  logic        ID_Use_RS2;
  logic        ID_Branch;
  logic        Branch_Taken;
  logic [4:0]  ID_EX_RD;
  logic        ID_EX_RegWrite;
  logic        ID_EX_MemRead;
  logic        ID_EX_MulDiv;
  logic [4:0]  EX_MEM_RD;
  logic        EX_MEM_MemRead;

  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        ID_EX_NoOp;
  logic        ID_EX_Hold;
  logic        EX_MEM_NoOp;
  logic        MD_Busy;
  logic [31:0] Stall_Cycles;
  logic [31:0] Flush_Count;

  modport slave (
    input  ID_RS1, ID_RS2, ID_Use_RS1, ID_Use_RS2, ID_Branch, Branch_Taken,
           ID_EX_RD, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulDiv, EX_MEM_RD, EX_MEM_MemRead,
    output PC_Write, IF_ID_Write, IF_Flush, ID_EX_NoOp, ID_EX_Hold, EX_MEM_NoOp, MD_Busy,
           Stall_Cycles, Flush_Count
  );

  modport master (
    output ID_RS1, ID_RS2, ID_Use_RS1, ID_Use_RS2, ID_Branch, Branch_Taken,
           ID_EX_RD, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MulDiv, EX_MEM_RD, EX_MEM_MemRead,
    input  PC_Write, IF_ID_Write, IF_Flush, ID_EX_NoOp, ID_EX_Hold, EX_MEM_NoOp, MD_Busy,
           Stall_Cycles, Flush_Count
  );

endinterface

// File: rtl/md_interlock.sv
// MUL/DIV interlock: keeps a MUL/DIV instruction in EX for MD_LATENCY cycles.
//   clk_i, rst_i : clock, synchronous active-high reset
//   mul_div      : instruction in EX is MUL/DIV
//   md_stall     : hold the pipeline this cycle
//   md_busy      : FSM is in BUSY
// MD_LATENCY of 1 removes the FSM entirely.
module md_interlock
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mul_div,
  output logic md_stall,
  output logic md_busy
);

  if (MD_LATENCY >= 2) begin : g_fsm
    // The IDLE cycle that accepts the op is itself a stall cycle, hence the -2.
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(MD_LATENCY - 2);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (mul_div) begin
            state_d = BUSY;
            cnt_d   = CntInit;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      md_stall = 1'b0;
      md_busy  = (state_q == BUSY);
      unique case (state_q)
        IDLE:    md_stall = mul_div;
        BUSY:    md_stall = (cnt_q != '0);
        default: md_stall = 1'b0;
      endcase
    end
  end else begin : g_no_fsm
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, mul_div};
    assign md_stall      = 1'b0;
    assign md_busy       = 1'b0;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside the ID stage of a 5-stage RISC-V pipeline.
//   clk_i, rst_i : clock, synchronous active-high reset
//   hz (slave)   : ID/EX/MEM hazard fields in; PC/IF_ID enables, flush, bubble and
//                  hold controls, MD_Busy and perf counters out
// Priority: reset > MUL/DIV interlock > load-use / branch operand stall > taken flush.
// HAZARD_PERF_EN: when defined, Stall_Cycles and Flush_Count count PC_Write=0 and
// IF_Flush=1 cycles outside reset; otherwise both read 0.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W      = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_stall_unit_if.slave hz
);

  logic md_stall, md_busy;
  logic load_use, br_ex, br_mem;
  logic pc_write, if_id_write, if_flush, id_ex_noop, id_ex_hold, ex_mem_noop;

  md_interlock #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_interlock (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .mul_div (hz.ID_EX_MulDiv),
    .md_stall(md_stall),
    .md_busy (md_busy)
  );

  assign load_use = hz.ID_EX_MemRead &&
                    reg_match(hz.ID_EX_RD, hz.ID_RS1, hz.ID_Use_RS1, hz.ID_RS2, hz.ID_Use_RS2);
  assign br_ex    = hz.ID_Branch && hz.ID_EX_RegWrite &&
                    reg_match(hz.ID_EX_RD, hz.ID_RS1, hz.ID_Use_RS1, hz.ID_RS2, hz.ID_Use_RS2);
  assign br_mem   = hz.ID_Branch && hz.EX_MEM_MemRead &&
                    reg_match(hz.EX_MEM_RD, hz.ID_RS1, hz.ID_Use_RS1, hz.ID_RS2, hz.ID_Use_RS2);

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_noop  = 1'b0;
    id_ex_hold  = 1'b0;
    ex_mem_noop = 1'b0;
    if (rst_i) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_flush    = 1'b1;
      id_ex_noop  = 1'b1;
      ex_mem_noop = 1'b1;
    end else if (md_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
      ex_mem_noop = 1'b1;
    end else if (load_use || br_ex || br_mem) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_noop  = 1'b1;
    end else if (hz.ID_Branch && hz.Branch_Taken) begin
      if_flush    = 1'b1;
    end
  end

  assign hz.PC_Write    = pc_write;
  assign hz.IF_ID_Write = if_id_write;
  assign hz.IF_Flush    = if_flush;
  assign hz.ID_EX_NoOp  = id_ex_noop;
  assign hz.ID_EX_Hold  = id_ex_hold;
  assign hz.EX_MEM_NoOp = ex_mem_noop;
  // The FSM may still hold BUSY during the first reset cycle; hide it.
  assign hz.MD_Busy     = md_busy && !rst_i;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_flush)  flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign hz.Stall_Cycles = stall_cycles_q;
  assign hz.Flush_Count  = flush_count_q;
`else
  assign hz.Stall_Cycles = 32'd0;
  assign hz.Flush_Count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit. The reference model tracks how many
// cycles the instruction in EX has already been held there (its age) and derives
// every control from the priority rules; perf counters are modelled as plain sums.
module tb_hazard_stall_unit;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz ();

  hazard_stall_unit #(
    .MD_LATENCY(L),
    .CNT_W     (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz)
  );

  int          errors = 0;
  int          checks = 0;
  int          age    = 0;   // cycles the current EX instruction has already stalled in EX
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  function automatic logic dep_on(input logic [4:0] rd);
    return (rd != 5'd0) && ((hz.ID_Use_RS1 && hz.ID_RS1 == rd) ||
                            (hz.ID_Use_RS2 && hz.ID_RS2 == rd));
  endfunction

  function automatic logic md_stall_m();
    return (L >= 2) && hz.ID_EX_MulDiv && (age < L - 1);
  endfunction

  // {PC_Write, IF_ID_Write, IF_Flush, ID_EX_NoOp, ID_EX_Hold, EX_MEM_NoOp, MD_Busy}
  function automatic logic [6:0] model_ctrl();
    logic busy, hazard;
    busy   = (age >= 1);
    hazard = (hz.ID_EX_MemRead && dep_on(hz.ID_EX_RD)) ||
             (hz.ID_Branch && hz.ID_EX_RegWrite && dep_on(hz.ID_EX_RD)) ||
             (hz.ID_Branch && hz.EX_MEM_MemRead && dep_on(hz.EX_MEM_RD));
    if (rst)                              return 7'b0011010;
    if (md_stall_m())                     return {6'b000011, busy};
    if (hazard)                           return {6'b000100, busy};
    if (hz.ID_Branch && hz.Branch_Taken)  return {6'b111000, busy};
    return {6'b110000, busy};
  endfunction

  function automatic logic [6:0] got_ctrl();
    return {hz.PC_Write, hz.IF_ID_Write, hz.IF_Flush, hz.ID_EX_NoOp, hz.ID_EX_Hold,
            hz.EX_MEM_NoOp, hz.MD_Busy};
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef HAZARD_PERF_EN
    return {m_stall, m_flush};
`else
    return 64'd0;
`endif
  endfunction

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    logic [6:0] c;
    logic       md;
    c  = model_ctrl();
    md = md_stall_m();
    @(posedge clk);
    if (rst) begin
      age     = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      age = md ? age + 1 : 0;
      if (!c[6]) m_stall = m_stall + 1;
      if (c[4])  m_flush = m_flush + 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    hz.ID_RS1 = 0; hz.ID_RS2 = 0; hz.ID_Use_RS1 = 0; hz.ID_Use_RS2 = 0;
    hz.ID_Branch = 0; hz.Branch_Taken = 0; hz.ID_EX_RD = 0; hz.ID_EX_RegWrite = 0;
    hz.ID_EX_MemRead = 0; hz.ID_EX_MulDiv = 0; hz.EX_MEM_RD = 0; hz.EX_MEM_MemRead = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    #1;
    checks++;
    if (got_ctrl() !== 7'b0011010) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b", got_ctrl(), 7'b0011010);
    end
    checks++;
    if ({hz.Stall_Cycles, hz.Flush_Count} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0", {hz.Stall_Cycles, hz.Flush_Count});
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    for (int v = 0; v < 2; v++) begin
      clear_inputs();
      hz.ID_EX_MemRead = 1; hz.ID_EX_RD = (v == 0) ? 5'd5 : 5'd0;
      hz.ID_RS1 = (v == 0) ? 5'd5 : 5'd0; hz.ID_Use_RS1 = 1;
      for (int c = 0; c < 2; c++) begin
        #1;
        checks++;
        if (got_ctrl() !== model_ctrl()) begin
          errors++;
          $display("FAIL load_use v%0d c%0d: got %b want %b", v, c, got_ctrl(), model_ctrl());
        end
        checks++;
        if ({hz.Stall_Cycles, hz.Flush_Count} !== exp_cnt()) begin
          errors++;
          $display("FAIL load_use_cnt: got %h want %h", {hz.Stall_Cycles, hz.Flush_Count},
                   exp_cnt());
        end
        tick();
        clear_inputs();  // bubble now sits in EX
      end
    end
  endtask

  task automatic test_branch_after_load();
    int stalls = 0;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      if (c < 3) begin
        hz.ID_Branch = 1; hz.Branch_Taken = 1;
        hz.ID_RS1 = 7; hz.ID_Use_RS1 = 1; hz.ID_RS2 = 3; hz.ID_Use_RS2 = 1;
      end
      if (c == 0) begin
        hz.ID_EX_MemRead = 1; hz.ID_EX_RegWrite = 1; hz.ID_EX_RD = 7;
      end
      if (c == 1) begin
        hz.EX_MEM_MemRead = 1; hz.EX_MEM_RD = 7;
      end
      #1;
      if (!hz.PC_Write) stalls++;
      checks++;
      if (got_ctrl() !== model_ctrl()) begin
        errors++;
        $display("FAIL br_load c%0d: got %b want %b", c, got_ctrl(), model_ctrl());
      end
      tick();
    end
    checks++;
    if (stalls !== 2) begin
      errors++;
      $display("FAIL br_load_stalls: got %0d want 2", stalls);
    end
  endtask

  task automatic test_muldiv(input int n_ops, input logic branch);
    clear_inputs();
    for (int c = 0; c < n_ops * L + 1; c++) begin
      hz.ID_EX_MulDiv = (c < n_ops * L);
      hz.ID_Branch    = branch && (c < L);
      hz.Branch_Taken = branch && (c < L);
      #1;
      checks++;
      if (got_ctrl() !== model_ctrl()) begin
        errors++;
        $display("FAIL muldiv n%0d br%0b c%0d: got %b want %b", n_ops, branch, c, got_ctrl(),
                 model_ctrl());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    hz.ID_EX_MulDiv = 1;
    for (int c = 0; c < 4; c++) begin
      rst = (c == 2);
      if (c == 3) hz.ID_EX_MulDiv = 0;
      #1;
      checks++;
      if (got_ctrl() !== model_ctrl()) begin
        errors++;
        $display("FAIL reset_busy c%0d: got %b want %b", c, got_ctrl(), model_ctrl());
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_perf();
    logic [63:0] want;
    rst = 1'b1; clear_inputs(); tick();
    rst = 1'b0;
    hz.ID_EX_MemRead = 1; hz.ID_EX_RD = 9; hz.ID_RS2 = 9; hz.ID_Use_RS2 = 1; tick();
    clear_inputs(); hz.ID_Branch = 1; hz.Branch_Taken = 1; tick();
    clear_inputs(); tick();
`ifdef HAZARD_PERF_EN
    want = {32'd1, 32'd1};
`else
    want = 64'd0;
`endif
    checks++;
    if ({hz.Stall_Cycles, hz.Flush_Count} !== want) begin
      errors++;
      $display("FAIL perf: got %h want %h", {hz.Stall_Cycles, hz.Flush_Count}, want);
    end
  endtask

  task automatic test_random(input int n);
    logic hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      rst              = ($urandom_range(0, 49) == 0);
      hz.ID_RS1        = 5'($urandom_range(0, 3));
      hz.ID_RS2        = 5'($urandom_range(0, 3));
      hz.ID_Use_RS1    = 1'($urandom);
      hz.ID_Use_RS2    = 1'($urandom);
      hz.ID_Branch     = 1'($urandom);
      hz.Branch_Taken  = 1'($urandom);
      hz.ID_EX_RD      = 5'($urandom_range(0, 3));
      hz.ID_EX_RegWrite = 1'($urandom);
      hz.ID_EX_MemRead = ($urandom_range(0, 3) == 0);
      // A held MUL/DIV stays in EX; otherwise a new one shows up now and then.
      hz.ID_EX_MulDiv  = hold || ($urandom_range(0, 7) == 0);
      hz.EX_MEM_RD     = 5'($urandom_range(0, 3));
      hz.EX_MEM_MemRead = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (got_ctrl() !== model_ctrl()) begin
        errors++;
        $display("FAIL random i%0d: got %b want %b", i, got_ctrl(), model_ctrl());
      end
      checks++;
      if ({hz.Stall_Cycles, hz.Flush_Count} !== exp_cnt()) begin
        errors++;
        $display("FAIL random_cnt i%0d: got %h want %h", i, {hz.Stall_Cycles, hz.Flush_Count},
                 exp_cnt());
      end
      hold = md_stall_m() && !rst;
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_muldiv(1, 1'b0);
    test_muldiv(2, 1'b0);
    test_muldiv(1, 1'b1);
    test_reset_busy();
    test_perf();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
